// File: rtl/dom_and_pipe.sv
// dom_and_pipe: d-th order domain-oriented masked AND gadget.
// Inner and cross-domain products are registered together before compression.
module dom_and_pipe #(
  parameter int ORDER = 3,
  parameter int WIDTH = 1,
  parameter bit OUT_REG = 1'b1,
  localparam int N = ORDER + 1,
  localparam int P = N * (N - 1) / 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [N*WIDTH-1:0] X_i,
  input  logic [N*WIDTH-1:0] Y_i,
  input  logic [P*WIDTH-1:0] Z_i,
  output logic [N*WIDTH-1:0] Q_o,
  output logic               valid_o
);

  localparam int C = N * (N - 1);

  function automatic int pidx(int i, int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // Ordered off-diagonal pair (i,j) packed into 0..N*(N-1)-1.
  function automatic int xidx(int i, int j);
    return i * (N - 1) + ((j < i) ? j : j - 1);
  endfunction

  logic [N-1:0][WIDTH-1:0] inner_d;
  logic [N-1:0][WIDTH-1:0] inner_q;
  logic [C-1:0][WIDTH-1:0] cross_d;
  logic [C-1:0][WIDTH-1:0] cross_q;
  logic                    v1_q;
  logic [N*WIDTH-1:0]      q_c;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar i = 0; i < N; i++) begin : g_sh
      logic [N-1:0] acc;

      assign inner_d[i][b] = X_i[i*WIDTH+b] & Y_i[i*WIDTH+b];

      for (genvar j = 0; j < N; j++) begin : g_j
        if (j == i) begin : g_in
          assign acc[j] = inner_q[i][b];
        end else begin : g_cr
          assign cross_d[xidx(i, j)][b] =
            (X_i[i*WIDTH+b] & Y_i[j*WIDTH+b]) ^ Z_i[b*P+pidx(i, j)];
          assign acc[j] = cross_q[xidx(i, j)][b];
        end
      end

      assign q_c[i*WIDTH+b] = ^acc;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inner_q <= '0;
      cross_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        inner_q <= inner_d;
        cross_q <= cross_d;
      end
    end
  end

  if (OUT_REG) begin : g_oreg
    logic [N*WIDTH-1:0] q_q;
    logic               v2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        q_q  <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) q_q <= q_c;
      end
    end

    assign Q_o     = q_q;
    assign valid_o = v2_q;
  end else begin : g_ocomb
    assign Q_o     = q_c;
    assign valid_o = v1_q;
  end

endmodule

// File: tb/tb_dom_and_pipe.sv
// tb_dom_and_pipe: three configurations of the masked AND gadget
// checked against a share-level and an unmasked reference.
module tb_dom_and_pipe;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [2:0]  vi;
  logic [2:0]  vo;
  logic [31:0] x0, y0, q0;
  logic [47:0] z0;
  logic [23:0] x1, y1, q1, z1;
  logic [1:0]  x2, y2, q2;
  logic [0:0]  z2;

  dom_and_pipe #(.ORDER(3), .WIDTH(8), .OUT_REG(1'b1)) u_d0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[0]), .X_i(x0),
    .Y_i(y0), .Z_i(z0), .Q_o(q0), .valid_o(vo[0]));

  dom_and_pipe #(.ORDER(2), .WIDTH(8), .OUT_REG(1'b0)) u_d1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[1]), .X_i(x1),
    .Y_i(y1), .Z_i(z1), .Q_o(q1), .valid_o(vo[1]));

  dom_and_pipe #(.ORDER(1), .WIDTH(1), .OUT_REG(1'b1)) u_d2 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(vi[2]), .X_i(x2),
    .Y_i(y2), .Z_i(z2), .Q_o(q2), .valid_o(vo[2]));

  int nn [3] = '{4, 3, 2};
  int ww [3] = '{8, 8, 1};
  int lat [3] = '{2, 1, 2};

  int cyc;
  int n_assert;
  int n_fail;

  logic [63:0] sq [3][16];
  logic [7:0]  su [3][16];
  bit          sv [3][16];
  logic [63:0] last [3];

  function automatic logic [63:0] dom_ref(int n, int w,
      logic [63:0] x, logic [63:0] y, logic [63:0] z);
    logic [63:0] q;
    bit zz [4][4];
    bit t;
    int k;
    int p;
    q = '0;
    p = n * (n - 1) / 2;
    for (int b = 0; b < w; b++) begin
      k = 0;
      for (int i = 0; i < n; i++)
        for (int j = i + 1; j < n; j++) begin
          zz[i][j] = z[b*p+k];
          zz[j][i] = z[b*p+k];
          k++;
        end
      for (int s = 0; s < n; s++) begin
        t = x[s*w+b] & y[s*w+b];
        for (int j = 0; j < n; j++)
          if (j != s) t ^= (x[s*w+b] & y[j*w+b]) ^ zz[s][j];
        q[s*w+b] = t;
      end
    end
    return q;
  endfunction

  function automatic logic [7:0] fold(int n, int w, logic [63:0] q);
    logic [63:0] r;
    r = '0;
    for (int s = 0; s < n; s++)
      r ^= (q >> (s * w)) & ((64'd1 << w) - 64'd1);
    return r[7:0];
  endfunction

  function automatic logic [63:0] split(int n, int w, logic [7:0] v);
    logic [63:0] sh;
    logic [7:0]  acc;
    logic [7:0]  r;
    logic [7:0]  m;
    m = (w == 8) ? 8'hFF : 8'h01;
    sh = '0;
    acc = v & m;
    for (int s = 0; s < n - 1; s++) begin
      r = 8'($urandom) & m;
      sh |= 64'(r) << (s * w);
      acc ^= r;
    end
    sh |= 64'(acc) << ((n - 1) * w);
    return sh;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] qout(int d);
    case (d)
      0: return {32'b0, q0};
      1: return {40'b0, q1};
      default: return {62'b0, q2};
    endcase
  endfunction

  task automatic drive(int d, bit v, logic [63:0] x,
      logic [63:0] y, logic [63:0] z);
    int slot;
    case (d)
      0: begin vi[0] = v; x0 = x[31:0]; y0 = y[31:0]; z0 = z[47:0]; end
      1: begin vi[1] = v; x1 = x[23:0]; y1 = y[23:0]; z1 = z[23:0]; end
      default: begin vi[2] = v; x2 = x[1:0]; y2 = y[1:0]; z2 = z[0:0]; end
    endcase
    if (v) begin
      slot = (cyc + lat[d]) % 16;
      sq[d][slot] = dom_ref(nn[d], ww[d], x, y, z);
      su[d][slot] = fold(nn[d], ww[d], x) & fold(nn[d], ww[d], y);
      sv[d][slot] = 1'b1;
    end
  endtask

  task automatic idle_all(bit rnd);
    for (int d = 0; d < 3; d++)
      if (rnd) drive(d, 1'b0, rnd64(), rnd64(), rnd64());
      else drive(d, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    int  slot;
    bit  ev;
    @(posedge clk_i);
    #1;
    cyc++;
    slot = cyc % 16;
    for (int d = 0; d < 3; d++) begin
      ev = sv[d][slot];
      chk($sformatf("valid_o[%0d]@%0d", d, cyc), 64'(vo[d]), 64'(ev));
      if (ev) begin
        last[d] = sq[d][slot];
        sv[d][slot] = 1'b0;
        chk($sformatf("unmasked[%0d]@%0d", d, cyc),
            64'(fold(nn[d], ww[d], qout(d))), 64'(su[d][slot]));
      end
      chk($sformatf("Q[%0d]@%0d", d, cyc), qout(d), last[d]);
    end
  endtask

  task automatic async_reset();
    rst_i = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_Q[%0d]", d), qout(d), 64'd0);
      chk($sformatf("rst_valid[%0d]", d), 64'(vo[d]), 64'd0);
      last[d] = '0;
      for (int s = 0; s < 16; s++) sv[d][s] = 1'b0;
    end
  endtask

  logic [7:0] xa [3] = '{8'hA5, 8'hFF, 8'h00};
  logic [7:0] ua [3] = '{8'h24, 8'h3C, 8'h00};
  logic [63:0] zk;
  logic [7:0]  xv;
  logic [7:0]  yv;

  initial begin
    cyc = 0;
    n_assert = 0;
    n_fail = 0;
    vi = '0;
    x0 = '0; y0 = '0; z0 = '0;
    x1 = '0; y1 = '0; z1 = '0;
    x2 = '0; y2 = '0; z2 = '0;
    for (int d = 0; d < 3; d++) begin
      last[d] = '0;
      for (int s = 0; s < 16; s++) sv[d][s] = 1'b0;
    end
    async_reset();
    step();
    step();
    rst_i = 1'b0;

    // 2-share directed case
    drive(2, 1'b1, 64'b01, 64'b10, 64'b1);
    step();
    drive(2, 1'b0, '0, '0, '0);
    step();
    chk("o1_shares", 64'(q2), 64'b10);
    chk("o1_valid", 64'(vo[2]), 64'd1);
    step();

    // back-to-back on the combinational-output instance
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'b1, split(3, 8, xa[i]), split(3, 8, 8'h3C), rnd64());
      step();
      chk($sformatf("b2b_unmasked%0d", i), 64'(fold(3, 8, qout(1))),
          64'(ua[i]));
    end
    drive(1, 1'b0, '0, '0, '0);
    step();

    // each pair index lights exactly its two shares
    for (int k = 0; k < 6; k++) begin
      zk = '0;
      for (int b = 0; b < 8; b++) zk[b*6+k] = 1'b1;
      drive(0, 1'b1, '0, '0, zk);
      step();
    end
    drive(0, 1'b0, '0, '0, '0);
    step();
    chk("zmap_k5", qout(0), {32'b0, 8'hFF, 8'hFF, 16'h0});
    step();

    // hold while inputs toggle
    drive(0, 1'b1, split(4, 8, 8'h5A), split(4, 8, 8'hC3), rnd64());
    drive(1, 1'b1, split(3, 8, 8'h96), split(3, 8, 8'h0F), rnd64());
    step();
    for (int i = 0; i < 6; i++) begin
      idle_all(1'b1);
      step();
    end

    for (int it = 0; it < 600; it++) begin
      for (int d = 0; d < 3; d++) begin
        xv = 8'($urandom);
        yv = 8'($urandom);
        drive(d, $urandom_range(0, 3) != 0, split(nn[d], ww[d], xv),
              split(nn[d], ww[d], yv), rnd64());
      end
      if (it == 300) begin
        for (int d = 0; d < 3; d++)
          drive(d, 1'b1, split(nn[d], ww[d], 8'hFF),
                split(nn[d], ww[d], 8'hFF), rnd64());
        async_reset();
        step();
        rst_i = 1'b0;
        for (int d = 0; d < 3; d++)
          drive(d, 1'b1, split(nn[d], ww[d], 8'hF0),
                split(nn[d], ww[d], 8'h3C), rnd64());
      end
      step();
    end
    idle_all(1'b0);
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dom_and_pipe.md
# dom_and_pipe

Parametrised d-th-order domain-oriented masked (DOM) AND gadget with a valid-qualified pipeline. It computes Q = X & Y bitwise over WIDTH bits, with every operand split into N = ORDER+1 Boolean shares, and uses ORDER·(ORDER+1)/2 fresh random bits per data bit for resharing. Both the inner-domain and cross-domain products are registered in the same stage, so output shares are never mixed combinationally with unregistered inputs. It is the generic masked-AND building block for masked S-box and datapath cores, replacing fixed-order gadgets.

## Interface
- ORDER, 3, masking order d ≥ 1; share count N = ORDER+1 (localparam).
- WIDTH, 1, independent data bits processed in parallel (≥ 1).
- OUT_REG, 1, 1 = register compressed output shares (latency 2); 0 = combinational compression after the resharing stage (latency 1).
- Localparam P = N·(N−1)/2, random bits per data bit.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  X_i, Y_i and Z_i carry a new operation this cycle.
- X_i  input  N·WIDTH  shares of X; share s of bit b is at X_i[s·WIDTH+b].
- Y_i  input  N·WIDTH  shares of Y; same layout as X_i.
- Z_i  input  P·WIDTH  fresh randomness; pair index k of bit b is at Z_i[b·P+k].
- Q_o  output  N·WIDTH  output shares; same layout as X_i.
- valid_o  output  1  Q_o holds the result of one accepted operation.

## Operation
- Pair index: each unordered share pair (i, j) with i < j is numbered lexicographically, k = 0..P−1: (0,1)=0, (0,2)=1, …, (0,N−1), (1,2), …, (N−2,N−1)=P−1.
- Stage 1 register, per bit b, loaded only when valid_i = 1:
  - inner[s] ← X_s & Y_s, for s = 0..N−1.
  - cross[i][j] ← (X_i & Y_j) ^ Z[k(i,j)], for all i ≠ j. The same Z bit masks (i,j) and (j,i).
- Compression, per bit and share: Q_s = inner[s] ^ XOR over j≠s of cross[s][j].
- OUT_REG = 1: a stage 2 register captures Q_s when the stage 1 valid bit is 1.
- Correctness invariant: XOR over s of Q_s = (XOR over s of X_s) & (XOR over s of Y_s), for every bit.
- valid_i = 0: every data register holds its value. No register is loaded with non-fresh randomness.
- No backpressure. Fresh Z is required on every valid_i cycle. Reusing Z breaks d-probing security but not functional correctness.
- Reset, asynchronous, any time: all stage registers go to 0 and the valid pipeline clears. Any operation in flight is discarded and produces no valid_o.
- ORDER = 1 degenerates to the 2-share DOM AND with a single random bit per data bit.

## Timing
- Reset values: Q_o = 0 (all shares), valid_o = 0.
- Latency from valid_i sampled high to valid_o high: 1 + OUT_REG cycles.
- Throughput: one operation per cycle. Back-to-back valid_i pulses give back-to-back valid_o pulses in order.
- valid_o is a single-cycle pulse per accepted operation.
- Between pulses, Q_o holds the last result: both stages hold when their valid input is 0.
- OUT_REG = 0: Q_o is combinational from stage 1 registers only, with no path from X_i, Y_i or Z_i.
- Reset deasserted with valid_i = 1 in the same cycle: the first sampling edge after deassertion accepts the operation.

## Test plan
- Reset: assert rst_i mid-stream with valid_i = 1 → Q_o = 0 and valid_o = 0 immediately. No valid_o for operations in flight; the first post-reset operation appears after 1+OUT_REG cycles.
- ORDER=1, WIDTH=1, OUT_REG=1: X shares (1,0), Y shares (0,1), Z = 1 → after 2 cycles Q shares (0,1), XOR = 1, valid_o = 1 for exactly one cycle.
- ORDER=3, WIDTH=1: exhaustive x,y ∈ {0,1}, 1000 random share splits each, random Z → unmasked Q = x & y every time. Latency is 2 with OUT_REG=1 and 1 with OUT_REG=0.
- ORDER=2, WIDTH=8: back-to-back valid_i with x = 0xA5, then 0xFF, then 0x00, and y = 0x3C → unmasked outputs 0x24, 0x3C, 0x00 on consecutive valid_o cycles.
- Hold: one operation, then valid_i = 0 for 5 cycles while X_i, Y_i and Z_i toggle randomly → Q_o is constant and valid_o stays 0.
- Randomness mapping, ORDER=3: X = Y = all-zero shares, Z = 1 only at k=2, pair (0,3) → Q shares (1,0,0,1). Repeat for each k: Q_i = Q_j = 1 exactly for that pair.
